// File: rtl/input_debounce.sv
// ----------------------------------------------------------------------------
// input_debounce
//
// Debounces and synchronises raw board push-buttons and switches
// (button_next, button_run, button_hlt, sw_code_edit, sw_clk) before they reach
// the cpu top level. Each channel yields a clean level plus single-cycle
// press/release pulses, so a bouncing contact cannot double-step code_pointer
// or glitch flag_hlt_ext.
//
// Ports:
//   clock_50MHz    in   1     system clock, all state updates on its rising edge
//   button_rst     in   1     asynchronous active-low reset (release synchronised)
//   raw_in         in   N_IN  unsynchronised board inputs
//   clean_out      out  N_IN  debounced level, same polarity as raw_in
//   press_pulse    out  N_IN  1-cycle pulse when clean_out leaves IDLE_LEVEL
//   release_pulse  out  N_IN  1-cycle pulse when clean_out returns to IDLE_LEVEL
//
// Optional feature macro: DEBOUNCE_AUTO_REPEAT_EN
//   Defined   : a held channel emits extra press pulses, the first REPEAT_DELAY
//               cycles after the press, then every REPEAT_PERIOD cycles.
//   Undefined : exactly one press pulse per debounced press; no hold counters.
//
// Latency: a raw edge sampled at clock edge k changes clean_out (and pulses)
// at edge k+1+DEBOUNCE_CYCLES.
// ----------------------------------------------------------------------------
module input_debounce #(
    parameter int unsigned N_IN            = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic        IDLE_LEVEL      = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic            clock_50MHz,
    input  logic            button_rst,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] clean_out,
    output logic [N_IN-1:0] press_pulse,
    output logic [N_IN-1:0] release_pulse
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("input_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        StStable,
        StPending
    } state_e;

    // ------------------------------------------------------------------------
    // Reset synchroniser: asserts asynchronously, releases on a clock edge
    // ------------------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clock_50MHz or negedge button_rst) begin
        if (!button_rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------------
    // Signal declarations
    // ------------------------------------------------------------------------
    logic [N_IN-1:0]  s1_q, s1_d;
    logic [N_IN-1:0]  s2_q, s2_d;
    logic [N_IN-1:0]  clean_q, clean_d;
    logic [N_IN-1:0]  press_q, press_d;
    logic [N_IN-1:0]  release_q, release_d;
    state_e           state_q [N_IN];
    state_e           state_d [N_IN];
    logic [CNT_W-1:0] cnt_q   [N_IN];
    logic [CNT_W-1:0] cnt_d   [N_IN];
    logic [N_IN-1:0]  differ;
    logic [N_IN-1:0]  fire;
    logic [N_IN-1:0]  rep_fire;

    // 2-flop synchroniser; only s2 is used downstream.
    always_comb begin
        s1_d = raw_in;
        s2_d = s1_q;
    end

    assign differ = s2_q ^ clean_q;

    // ------------------------------------------------------------------------
    // Transition decode: the debounced level flips this cycle
    // ------------------------------------------------------------------------
    always_comb begin
        fire = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (differ[i]) begin
                if (state_q[i] == StStable) begin
                    // Single-cycle debounce skips PENDING entirely.
                    fire[i] = (DEBOUNCE_CYCLES == 1);
                end else begin
                    fire[i] = (cnt_q[i] >= CNT_LAST);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                state_q[i] <= StStable;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StStable: begin
                    if (differ[i] && !fire[i]) begin
                        state_d[i] = StPending;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                StPending: begin
                    if (!differ[i] || fire[i]) begin
                        // Bounce back to the old level, or debounce complete.
                        state_d[i] = StStable;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = StStable;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM outputs: new level and registered pulses
    // ------------------------------------------------------------------------
    always_comb begin
        clean_d   = clean_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (fire[i]) begin
                clean_d[i]   = s2_q[i];
                press_d[i]   = (s2_q[i] != IDLE_LEVEL);
                release_d[i] = (s2_q[i] == IDLE_LEVEL);
            end else begin
                press_d[i] = rep_fire[i];
            end
        end
    end

    always_ff @(posedge clock_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= {N_IN{IDLE_LEVEL}};
            s2_q      <= {N_IN{IDLE_LEVEL}};
            clean_q   <= {N_IN{IDLE_LEVEL}};
            press_q   <= '0;
            release_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign clean_out     = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

    // ------------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------------
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam int unsigned HOLD_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned       HOLD_W      = $clog2(HOLD_SPAN + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = '1;
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt_q [N_IN];
    logic [HOLD_W-1:0] hold_cnt_d [N_IN];
    // 0: waiting out the initial delay, 1: repeating at the period rate.
    logic [N_IN-1:0]   rep_phase_q, rep_phase_d;

    always_comb begin
        rep_fire    = '0;
        rep_phase_d = rep_phase_q;
        for (int i = 0; i < N_IN; i++) begin
            hold_cnt_d[i] = hold_cnt_q[i];
            // A fresh press (or any release) restarts the hold timing.
            if (fire[i] || clean_q[i] == IDLE_LEVEL) begin
                hold_cnt_d[i]  = '0;
                rep_phase_d[i] = 1'b0;
            end else if (hold_cnt_q[i] >= (rep_phase_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
                rep_fire[i]    = 1'b1;
                hold_cnt_d[i]  = '0;
                rep_phase_d[i] = 1'b1;
            end else if (hold_cnt_q[i] != HOLD_MAX) begin
                hold_cnt_d[i] = hold_cnt_q[i] + HOLD_ONE;
            end
        end
    end

    always_ff @(posedge clock_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            rep_phase_q <= '0;
            for (int i = 0; i < N_IN; i++) begin
                hold_cnt_q[i] <= '0;
            end
        end else begin
            rep_phase_q <= rep_phase_d;
            for (int i = 0; i < N_IN; i++) begin
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: expected pulse events are queued
// with their due edge when stimulus is driven and compared every cycle.
module tb_input_debounce;

    localparam int unsigned N    = 5;
    localparam int unsigned DEB  = 4;
    localparam int unsigned RDLY = 10;
    localparam int unsigned RPER = 3;

    logic         clock_50MHz = 1'b0;
    logic         button_rst  = 1'b1;
    logic [N-1:0] raw_in      = '1;
    logic [N-1:0] clean_out;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;

    input_debounce #(
        .N_IN           (N),
        .DEBOUNCE_CYCLES(DEB),
        .IDLE_LEVEL     (1'b1),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clock_50MHz  (clock_50MHz),
        .button_rst   (button_rst),
        .raw_in       (raw_in),
        .clean_out    (clean_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clock_50MHz = ~clock_50MHz;

    int unsigned edge_n = 0;
    always @(posedge clock_50MHz) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned at;
        int unsigned ch;
        bit          is_press;
    } ev_t;

    ev_t          sb_q[$];
    int unsigned  n_cmp   = 0;
    int unsigned  n_err   = 0;
    bit           mon_en  = 1'b0;
    logic [N-1:0] exp_clean = '1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic expect_ev(input int unsigned at, input int unsigned ch, input bit is_press);
        ev_t ev;
        ev.at       = at;
        ev.ch       = ch;
        ev.is_press = is_press;
        sb_q.push_back(ev);
    endtask

    // Stimulus driven just after edge e is sampled at e+1 and lands at e+2+DEB.
    function automatic int unsigned due(input int unsigned e);
        return e + 2 + DEB;
    endfunction

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clock_50MHz);
        #1;
    endtask

    // Monitor: pop events due at this edge and compare outputs mid-cycle.
    always @(negedge clock_50MHz) begin
        logic [N-1:0] exp_p;
        logic [N-1:0] exp_r;
        if (mon_en) begin
            exp_p = '0;
            exp_r = '0;
            if (!button_rst) begin
                exp_clean = '1;
                sb_q.delete();
            end
            for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
                if (sb_q[i].at == edge_n) begin
                    if (sb_q[i].is_press) begin
                        exp_p[sb_q[i].ch]     = 1'b1;
                        exp_clean[sb_q[i].ch] = 1'b0;
                    end else begin
                        exp_r[sb_q[i].ch]     = 1'b1;
                        exp_clean[sb_q[i].ch] = 1'b1;
                    end
                    sb_q.delete(i);
                end
            end
            check_eq("press_pulse", 32'(press_pulse), 32'(exp_p));
            check_eq("release_pulse", 32'(release_pulse), 32'(exp_r));
            check_eq("clean_out", 32'(clean_out), 32'(exp_clean));
        end
    end

    initial begin
        int unsigned e;
        int unsigned p;
        int unsigned r;

        // Let the reset synchroniser settle high so the reset assertion is a real edge.
        step(3);

        // T1: reset held while raw inputs toggle randomly.
        button_rst = 1'b0;
        mon_en     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raw_in = N'($urandom);
            step(1);
        end
        raw_in = '1;
        step(2);
        button_rst = 1'b1;
        step(6);

        // T2: clean press on channel 0.
        e = edge_n;
        raw_in[0] = 1'b0;
        expect_ev(due(e), 0, 1'b1);
        step(12);

        // T3: bounce on channel 1 (3 low, 2 high) then steady low.
        raw_in[1] = 1'b0;
        step(3);
        raw_in[1] = 1'b1;
        step(2);
        e = edge_n;
        raw_in[1] = 1'b0;
        expect_ev(due(e), 1, 1'b1);
        step(12);

        // T4: simultaneous press then release on channels 2 and 4.
        e = edge_n;
        raw_in[2] = 1'b0;
        raw_in[4] = 1'b0;
        expect_ev(due(e), 2, 1'b1);
        expect_ev(due(e), 4, 1'b1);
        step(12);
        e = edge_n;
        raw_in[2] = 1'b1;
        raw_in[4] = 1'b1;
        expect_ev(due(e), 2, 1'b0);
        expect_ev(due(e), 4, 1'b0);
        step(12);

        // Release channels 0 and 1 together.
        e = edge_n;
        raw_in[0] = 1'b1;
        raw_in[1] = 1'b1;
        expect_ev(due(e), 0, 1'b0);
        expect_ev(due(e), 1, 1'b0);
        step(12);

        // T5: reset two cycles into PENDING on channel 3.
        raw_in[3] = 1'b0;
        step(4);
        button_rst = 1'b0;
        #1;
        check_eq("rst_async_clean", 32'(clean_out), 32'(5'b11111));
        check_eq("rst_async_press", 32'(press_pulse), 32'd0);
        check_eq("rst_async_release", 32'(release_pulse), 32'd0);
        raw_in[3] = 1'b1;
        step(3);
        button_rst = 1'b1;
        step(15);

        // T6: long hold on channel 0.
        e = edge_n;
        raw_in[0] = 1'b0;
        p = due(e);
        expect_ev(p, 0, 1'b1);
        step(30);
        e = edge_n;
        raw_in[0] = 1'b1;
        r = due(e);
        expect_ev(r, 0, 1'b0);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        for (int unsigned q = p + RDLY; q < r; q += RPER) begin
            expect_ev(q, 0, 1'b1);
        end
`endif
        step(15);

        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
